// File: rtl/dmem_line_ctrl.sv
// Line-granular data memory behind the data cache: 256-bit line reads/writes with a
// fixed off-chip latency countdown and saturating read/write completion counters.
module dmem_line_ctrl #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int IDX_W   = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o,
    output logic [15:0]  rd_cnt_o,
    output logic [15:0]  wr_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    logic [255:0]     mem [DEPTH];

    state_t           state_r;
    state_t           state_next_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_next_s;
    logic             commit_s;
    logic             accept_s;
    logic [IDX_W-1:0] idx_r;
    logic             wr_r;
    logic [255:0]     wdata_r;
    logic             ack_r;
    logic             busy_r;
    logic [255:0]     data_r;
    logic [15:0]      rd_cnt_r;
    logic [15:0]      wr_cnt_r;
    logic             unused_addr_s;

    // Only the line index bits of the address select a line; the rest alias.
    assign unused_addr_s = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    assign accept_s = (state_r == S_IDLE) && enable_i;

    // Next-state and countdown logic; commit_s marks the BUSY->ACK edge.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        commit_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (enable_i) begin
                    state_next_s = S_BUSY;
                    cnt_next_s   = LAT_M1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = S_ACK;
                    commit_s     = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r - 8'd1;
                end
            end
            S_ACK: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase
    end

    // State, countdown and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= S_IDLE;
            cnt_r   <= 8'd0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            ack_r   <= (state_next_s == S_ACK);
            busy_r  <= (state_next_s != S_IDLE);
        end
    end

    // Request capture in IDLE; later input changes are ignored until the next IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_r   <= '0;
            wr_r    <= 1'b0;
            wdata_r <= 256'd0;
        end else if (accept_s) begin
            idx_r   <= addr_i[5+IDX_W-1:5];
            wr_r    <= write_i;
            wdata_r <= data_i;
        end
    end

    // Read data and saturating completion counters, updated on the commit edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_r   <= 256'd0;
            rd_cnt_r <= 16'd0;
            wr_cnt_r <= 16'd0;
        end else if (commit_s) begin
            if (wr_r) begin
                if (wr_cnt_r != 16'hFFFF) begin
                    wr_cnt_r <= wr_cnt_r + 16'd1;
                end
            end else begin
                data_r <= mem[idx_r];
                if (rd_cnt_r != 16'hFFFF) begin
                    rd_cnt_r <= rd_cnt_r + 16'd1;
                end
            end
        end
    end

    // Line array; no reset so contents survive, and a reset before commit blocks the write.
    always_ff @(posedge clk_i) begin
        if (commit_s && wr_r) begin
            mem[idx_r] <= wdata_r;
        end
    end

    assign ack_o    = ack_r;
    assign busy_o   = busy_r;
    assign data_o   = data_r;
    assign rd_cnt_o = rd_cnt_r;
    assign wr_cnt_o = wr_cnt_r;

endmodule
